// File: rtl/multi_collision_detector.sv
// Per-channel paddle/ball collision detector: counts target-colour hit pixels per frame and pulses on threshold.
// Optional per-channel speed estimator compiled only with `define COLLISION_SPEED_EST_EN.
module multi_collision_detector #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CNT_W          = 12,
  parameter int unsigned HIT_THRESH     = 20,
  parameter int unsigned HOLDOFF_FRAMES = 8,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_ACTIVE       = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              x_pixel,
  input  logic [9:0]              y_pixel,
  input  logic                    DE,
  input  logic                    is_target_color,
  input  logic [NUM_CH-1:0]       is_hit_area,
  input  logic [NUM_CH-1:0]       arm,
  output logic [NUM_CH-1:0]       collision_detected,
  output logic                    collision_any,
  output logic [NUM_CH*CNT_W-1:0] hit_count,
  output logic [NUM_CH*8-1:0]     speed_est
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLDOFF_FRAMES);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    HOLDOFF  = 2'd2
  } state_t;

  logic             frame_end;
  logic             fe_valid;
  logic             synced_q;
  logic [CNT_W-1:0] cnt_q     [NUM_CH];
  logic [CNT_W-1:0] cnt_final [NUM_CH];
  logic [NUM_CH-1:0] over_thresh;
  state_t           state_q   [NUM_CH];
  state_t           state_d   [NUM_CH];
  logic [7:0]       hold_q    [NUM_CH];
  logic [7:0]       hold_d    [NUM_CH];
  logic [NUM_CH-1:0] pulse_d;

  assign frame_end = DE && (x_pixel == 10'(H_ACTIVE - 1)) && (y_pixel == 10'(V_ACTIVE - 1));
  // Frame-end effects are suppressed until one full frame boundary has been seen after reset
  assign fe_valid  = frame_end && synced_q;

  // Saturating running count including the current pixel
  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      cnt_final[n]   = cnt_q[n];
      over_thresh[n] = 1'b0;
      if (DE && is_target_color && is_hit_area[n] && (cnt_q[n] != CNT_MAX)) begin
        cnt_final[n] = cnt_q[n] + CNT_W'(1);
      end
      over_thresh[n] = (32'(cnt_final[n]) >= 32'(HIT_THRESH)) || (cnt_final[n] == CNT_MAX);
    end
  end

  // Running counters and per-frame snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      synced_q  <= 1'b0;
      hit_count <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      if (frame_end) begin
        synced_q <= 1'b1;
      end
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        cnt_q[n] <= frame_end ? '0 : cnt_final[n];
        if (fe_valid) begin
          hit_count[n*CNT_W +: CNT_W] <= cnt_final[n];
        end
      end
    end
  end

  // Per-channel arm / holdoff FSM
  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      state_d[n] = state_q[n];
      hold_d[n]  = hold_q[n];
      pulse_d[n] = 1'b0;
      case (state_q[n])
        DISARMED: begin
          if (arm[n]) begin
            state_d[n] = ARMED;
          end
        end
        ARMED: begin
          if (!arm[n]) begin
            state_d[n] = DISARMED;
          end else if (fe_valid && over_thresh[n]) begin
            pulse_d[n] = 1'b1;
            state_d[n] = HOLDOFF;
            hold_d[n]  = HOLD_LOAD;
          end
        end
        HOLDOFF: begin
          if (fe_valid) begin
            hold_d[n] = hold_q[n] - 8'd1;
            if (hold_q[n] == 8'd1) begin
              state_d[n] = arm[n] ? ARMED : DISARMED;
            end
          end
        end
        default: begin
          state_d[n] = DISARMED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collision_detected <= '0;
      collision_any      <= 1'b0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        state_q[n] <= DISARMED;
        hold_q[n]  <= '0;
      end
    end else begin
      collision_detected <= pulse_d;
      collision_any      <= |pulse_d;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        state_q[n] <= state_d[n];
        hold_q[n]  <= hold_d[n];
      end
    end
  end

`ifdef COLLISION_SPEED_EST_EN
  logic [7:0] streak_q [NUM_CH];
  logic [7:0] streak_d [NUM_CH];

  // Consecutive armed frames with a nonzero count, including the current frame
  always_comb begin
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      streak_d[n] = streak_q[n];
      if (fe_valid) begin
        if ((state_q[n] == ARMED) && arm[n] && (cnt_final[n] != '0)) begin
          streak_d[n] = (streak_q[n] == 8'hFF) ? streak_q[n] : streak_q[n] + 8'd1;
        end else begin
          streak_d[n] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_est <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        streak_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        streak_q[n] <= streak_d[n];
        if (pulse_d[n]) begin
          speed_est[n*8 +: 8] <= streak_d[n];
        end
      end
    end
  end
`else
  assign speed_est = '0;
`endif

endmodule

// File: tb/tb_multi_collision_detector.sv
// Scoreboard bench for multi_collision_detector: default instance plus a 4-bit-counter instance.
module tb_multi_collision_detector;

`ifdef COLLISION_SPEED_EST_EN
  localparam bit SPEED_ON = 1'b1;
`else
  localparam bit SPEED_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  x_pixel, y_pixel;
  logic        de, tgt;
  logic [1:0]  hit_area, arm;
  logic [1:0]  coll;
  logic        coll_any;
  logic [23:0] hit_count;
  logic [15:0] speed_est;
  logic        sat_coll, sat_any;
  logic [3:0]  sat_hc;
  logic [7:0]  sat_speed;

  always #20 clk = ~clk;

  multi_collision_detector u_dut (
    .clk(clk), .reset(rst_n), .x_pixel(x_pixel), .y_pixel(y_pixel), .DE(de),
    .is_target_color(tgt), .is_hit_area(hit_area), .arm(arm),
    .collision_detected(coll), .collision_any(coll_any),
    .hit_count(hit_count), .speed_est(speed_est)
  );

  multi_collision_detector #(.NUM_CH(1), .CNT_W(4), .HIT_THRESH(10)) u_sat (
    .clk(clk), .reset(rst_n), .x_pixel(x_pixel), .y_pixel(y_pixel), .DE(de),
    .is_target_color(tgt), .is_hit_area(hit_area[0]), .arm(arm[0]),
    .collision_detected(sat_coll), .collision_any(sat_any),
    .hit_count(sat_hc), .speed_est(sat_speed)
  );

  typedef struct packed {
    logic [1:0]  pulse;
    logic [11:0] hc0;
    logic [11:0] hc1;
    logic        psat;
    logic [3:0]  hcs;
    logic [15:0] sp;
    logic [7:0]  sps;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   obs_p0   = 0;

  // Reference model: index 0/1 = main channels, 2 = saturating instance (follows channel 0 inputs)
  int m_mode[3], m_hold[3], m_streak[3], m_speed[3], m_hc[3];
  int m_cap[3] = '{4095, 4095, 15};
  int m_thr[3] = '{20, 20, 10};
  bit m_sync;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_hold[k] = 0; m_streak[k] = 0; m_speed[k] = 0; m_hc[k] = 0;
    end
    m_sync = 1'b0;
  endtask

  task automatic drive(input logic de_v, input logic tgt_v, input logic [1:0] area_v,
                       input logic [1:0] arm_v, input int xv, input int yv);
    @(negedge clk);
    de = de_v; tgt = tgt_v; hit_area = area_v; arm = arm_v;
    x_pixel = 10'(xv); y_pixel = 10'(yv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    de = 1'b0; tgt = 1'b0; hit_area = '0; arm = '0; x_pixel = '0; y_pixel = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_pulse", {29'd0, sat_coll, coll, coll_any}, 32'd0);
    chk("rst_hc", {8'd0, hit_count}, 32'd0);
    chk("rst_sat_hc", {28'd0, sat_hc}, 32'd0);
    chk("rst_speed", {8'd0, sat_speed, speed_est}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One frame: h0/h1 matching pixels (last one on the frame-end pixel), arm av during, afe on frame end
  task automatic run_frame(input int h0, input int h1, input logic [1:0] av, input logic [1:0] afe);
    int   hk[3];
    int   c, mx, ci;
    logic a;
    logic [1:0] ar;
    logic [2:0] p;
    exp_t e;
    hk[0] = h0; hk[1] = h1; hk[2] = h0;
    mx = (h0 > h1) ? h0 : h1;
    drive(1'b0, 1'b1, 2'b11, av, 639, 479);
    drive(1'b1, 1'b0, 2'b11, av, 5, 5);
    for (int i = 0; i < mx - 1; i++) begin
      ar[0] = (i < h0 - 1);
      ar[1] = (i < h1 - 1);
      drive(1'b1, 1'b1, ar, av, i, 1);
    end
    p = '0;
    for (int k = 0; k < 3; k++) begin
      ci = (k == 1) ? 1 : 0;
      a = av[ci];
      if (m_mode[k] == 0 && a) m_mode[k] = 1;
      else if (m_mode[k] == 1 && !a) m_mode[k] = 0;
      a = afe[ci];
      c = (hk[k] > m_cap[k]) ? m_cap[k] : hk[k];
      if (!m_sync) begin
        if (m_mode[k] == 0 && a) m_mode[k] = 1;
        else if (m_mode[k] == 1 && !a) m_mode[k] = 0;
      end else begin
        if (m_mode[k] == 1 && a && c != 0) m_streak[k] = (m_streak[k] == 255) ? 255 : m_streak[k] + 1;
        else m_streak[k] = 0;
        m_hc[k] = c;
        case (m_mode[k])
          0: if (a) m_mode[k] = 1;
          1: begin
            if (!a) m_mode[k] = 0;
            else if (c >= m_thr[k]) begin
              p[k] = 1'b1; m_mode[k] = 2; m_hold[k] = 8; m_speed[k] = m_streak[k];
            end
          end
          default: begin
            m_hold[k]--;
            if (m_hold[k] == 0) m_mode[k] = a ? 1 : 0;
          end
        endcase
      end
    end
    m_sync = 1'b1;
    e.pulse = p[1:0];
    e.hc0   = 12'(m_hc[0]);
    e.hc1   = 12'(m_hc[1]);
    e.psat  = p[2];
    e.hcs   = 4'(m_hc[2]);
    e.sp    = SPEED_ON ? {8'(m_speed[1]), 8'(m_speed[0])} : 16'd0;
    e.sps   = SPEED_ON ? 8'(m_speed[2]) : 8'd0;
    sb.push_back(e);
    drive(1'b1, 1'b1, {logic'(h1 > 0), logic'(h0 > 0)}, afe, 639, 479);
    drive(1'b0, 1'b0, 2'b00, afe, 0, 0);
  endtask

  // Output monitor: frame-end cycles pop the scoreboard, all others must be pulse-free
  always @(posedge clk) begin
    logic fe_s;
    exp_t e;
    fe_s = rst_n && de && (x_pixel == 10'd639) && (y_pixel == 10'd479);
    #1;
    if (rst_n) begin
      if (fe_s) begin
        chk("sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          if (coll[0]) obs_p0++;
          chk("pulse", {30'd0, coll}, {30'd0, e.pulse});
          chk("any", {31'd0, coll_any}, {31'd0, |e.pulse});
          chk("hc0", {20'd0, hit_count[11:0]}, {20'd0, e.hc0});
          chk("hc1", {20'd0, hit_count[23:12]}, {20'd0, e.hc1});
          chk("sat_pulse", {31'd0, sat_coll}, {31'd0, e.psat});
          chk("sat_hc", {28'd0, sat_hc}, {28'd0, e.hcs});
          chk("speed", {16'd0, speed_est}, {16'd0, e.sp});
          chk("sat_speed", {24'd0, sat_speed}, {24'd0, e.sps});
        end
      end else begin
        chk("idle_pulse", {28'd0, sat_any, sat_coll, coll, coll_any}, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; de = 1'b0; tgt = 1'b0; hit_area = '0; arm = '0; x_pixel = '0; y_pixel = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("por_pulse", {29'd0, sat_coll, coll, coll_any}, 32'd0);
    chk("por_hc", {8'd0, hit_count}, 32'd0);
    chk("por_speed", {8'd0, sat_speed, speed_est}, 32'd0);
    rst_n = 1'b1;

    // Threshold: 20 on ch0 collides, 19 on ch1 does not
    run_frame(0, 0, 2'b00, 2'b00);
    run_frame(20, 19, 2'b11, 2'b11);

    // Reset mid-frame, then the partial frame is discarded
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 2'b11, 2'b11, i, 2);
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 2'b11, 2'b11, i, 3);
    run_frame(3, 3, 2'b11, 2'b11);

    // Simultaneous collisions
    run_frame(25, 25, 2'b11, 2'b11);

    // Holdoff: pulses on frames 1 and 10 only
    do_reset();
    run_frame(0, 0, 2'b00, 2'b00);
    obs_p0 = 0;
    for (int f = 0; f < 10; f++) run_frame(30, 0, 2'b01, 2'b01);
    chk("holdoff_pulses", 32'(obs_p0), 32'd2);

    // Disarm on the frame-end cycle wins, then re-arm
    do_reset();
    run_frame(0, 0, 2'b00, 2'b00);
    run_frame(25, 25, 2'b11, 2'b10);
    run_frame(25, 0, 2'b00, 2'b00);
    run_frame(25, 0, 2'b01, 2'b01);

    // Speed estimate: three 5-hit frames then a 25-hit frame
    do_reset();
    run_frame(0, 0, 2'b00, 2'b00);
    for (int f = 0; f < 3; f++) run_frame(5, 0, 2'b01, 2'b01);
    run_frame(25, 0, 2'b01, 2'b01);
    chk("speed_ch0", {24'd0, speed_est[7:0]}, SPEED_ON ? 32'd4 : 32'd0);

    // Saturation (4-bit instance) and a 19-hit non-collision on the main instance
    do_reset();
    run_frame(0, 0, 2'b00, 2'b00);
    run_frame(40, 0, 2'b01, 2'b01);
    chk("sat_hc_final", {28'd0, sat_hc}, 32'd15);
    do_reset();
    run_frame(0, 0, 2'b00, 2'b00);
    run_frame(19, 0, 2'b01, 2'b01);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
